// File: rtl/ddr3_frame_reader.sv
// Reads one JPEG frame from a DDR3 bank: one single-beat read command per column step, up to the end address.
// Latency: a returned beat is written to the FIFO at the rd_data_valid edge and shows on m_valid the next cycle.
// Backpressure: commands are issued only while reads in flight plus FIFO occupancy stay below FIFO_DEPTH.
module ddr3_frame_reader #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         DATA_W     = 128,
  parameter logic [2:0] CMD_RD     = 3'b001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              start,
  input  logic [2:0]        bank_sel,
  input  logic [13:0]       row_end,
  input  logic [9:0]        col_end,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              cmd_ready,
  output logic [2:0]        cmd,
  output logic              cmd_en,
  output logic [26:0]       addr,
  output logic [5:0]        app_burst_number,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  input  logic              rd_data_end,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        bank_q, bank_d;
  logic [13:0]       row_end_q, row_end_d;
  logic [6:0]        col_end_q, col_end_d;
  logic [13:0]       row_q, row_d;
  logic [6:0]        col_q, col_d;        // column in units of 8 (one BL8 burst)
  logic [21:0]       total_q, total_d;
  logic [21:0]       delivered_q, delivered_d;
  logic [CW-1:0]     out_q, out_d;        // reads accepted by the controller, data not yet back
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic          fifo_empty;
  logic [CW:0]   occupancy;
  logic          credit;
  logic          issue_en;
  logic          cmd_hs;
  logic          push;
  logic          pop;
  logic          last_addr;
  logic          head_last;
  logic          unused_inputs;

  // burst end marker carries no information with one beat per burst; low column bits are below burst granularity
  assign unused_inputs = ^{rd_data_end, col_end[2:0]};

  // handshake and occupancy terms shared by next-state logic and outputs
  always_comb begin
    fifo_empty = (cnt_q == '0);
    occupancy  = {1'b0, out_q} + {1'b0, cnt_q};
    credit     = (occupancy < (CW+1)'(FIFO_DEPTH));
    issue_en   = (state_q == ISSUE) && credit;
    cmd_hs     = issue_en && cmd_ready;
    push       = rd_data_valid && (out_q != '0);
    pop        = !fifo_empty && m_ready;
    last_addr  = (row_q == row_end_q) && (col_q == col_end_q);
    head_last  = (delivered_q == total_q - 22'd1);
  end

  // next-state: frame FSM, address walk, credit and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    row_end_d   = row_end_q;
    col_end_d   = col_end_q;
    row_d       = row_q;
    col_d       = col_q;
    total_d     = total_q;
    delivered_d = delivered_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q | (rd_data_valid && (out_q == '0));
    done_d      = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      delivered_d = delivered_q + 22'd1;
    end

    case ({cmd_hs, push})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start && init_calib_complete) begin
          bank_d      = bank_sel;
          row_end_d   = row_end;
          col_end_d   = col_end[9:3];
          total_d     = {1'b0, row_end, 7'd0} + {15'd0, col_end[9:3]} + 22'd1;
          row_d       = '0;
          col_d       = '0;
          delivered_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_hs) begin
          if (last_addr) begin
            state_d = DRAIN;
          end else begin
            col_d = col_q + 7'd1;
            if (col_q == 7'h7f) row_d = row_q + 14'd1;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      row_end_q   <= '0;
      col_end_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      total_q     <= '0;
      delivered_q <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      row_end_q   <= row_end_d;
      col_end_q   <= col_end_d;
      row_q       <= row_d;
      col_q       <= col_d;
      total_q     <= total_d;
      delivered_q <= delivered_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rd_data;
  end

  // outputs: command port, first-word fall-through stream, status
  always_comb begin
    busy             = (state_q != IDLE);
    done             = done_q;
    err              = err_q;
    cmd_en           = issue_en;
    cmd              = issue_en ? CMD_RD : 3'b000;
    addr             = {bank_q, row_q, col_q, 3'b000};
    app_burst_number = '0;
    m_valid          = !fifo_empty;
    m_data           = fifo_empty ? '0 : mem_q[rd_ptr_q];
    m_last           = !fifo_empty && head_last;
  end

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Bench for ddr3_frame_reader: random command stalls, read latencies and stream backpressure
// against an address/data model computed from the frame geometry.
// All DUT inputs change on the falling edge; outputs are sampled there too.
module tb_ddr3_frame_reader;

  localparam int         DEPTH  = 8;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_calib_complete = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   bank_sel = '0;
  logic [13:0]  row_end = '0;
  logic [9:0]   col_end = '0;
  logic         busy, done, err;
  logic         cmd_ready = 1'b0;
  logic [2:0]   cmd;
  logic         cmd_en;
  logic [26:0]  addr;
  logic [5:0]   app_burst_number;
  logic [127:0] rd_data = '0;
  logic         rd_data_valid = 1'b0;
  logic         rd_data_end = 1'b0;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;

  ddr3_frame_reader #(.FIFO_DEPTH(DEPTH), .DATA_W(128), .CMD_RD(CMD_RD)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .start(start), .bank_sel(bank_sel), .row_end(row_end), .col_end(col_end),
    .busy(busy), .done(done), .err(err),
    .cmd_ready(cmd_ready), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .app_burst_number(app_burst_number),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // memory contents as a function of address
  function automatic logic [127:0] data_of(input logic [26:0] a);
    logic [31:0] w;
    w = {5'd0, a};
    return {w ^ 32'hDEADBEEF, ~w, w * 32'h9E3779B1, w + 32'h12345678};
  endfunction

  // i-th address of a frame: 128 bursts of 8 columns per row
  function automatic logic [26:0] exp_addr(input logic [2:0] b, input int i);
    logic [13:0] r;
    logic [9:0]  c;
    r = 14'(i / 128);
    c = 10'((i % 128) * 8);
    return {b, r, c};
  endfunction

  int p_cmd = 100, p_m = 100, lat_min = 1, lat_max = 4;
  int cyc = 0;
  logic [26:0] ret_addr[$];
  int          ret_due[$];
  bit          frame_active = 0;
  logic [2:0]  f_bank;
  int          f_total = 0, n_cmd = 0, n_pop = 0;
  bit          last_pop_prev = 0;
  bit          hold_prev = 0;
  logic [26:0] hold_addr;
  bit          mhold_prev = 0;
  logic [127:0] mhold_dat;
  logic        mhold_last;

  // one cycle: check held values, then drive command, return and stream inputs
  task automatic step();
    logic [26:0] ra;
    @(negedge clk);
    cyc++;
    chk("done_pulse", done, last_pop_prev);
    last_pop_prev = 0;
    if (hold_prev) begin
      chk("cmd_hold_en", cmd_en, 1'b1);
      chk("cmd_hold_addr", addr, hold_addr);
      chk("cmd_hold_code", cmd, CMD_RD);
    end
    if (!frame_active) chk("idle_cmd_en", cmd_en, 1'b0);

    cmd_ready = ($urandom_range(99) < p_cmd);
    if (cmd_en && cmd_ready) begin
      if (frame_active) begin
        chk("cmd_addr", addr, exp_addr(f_bank, n_cmd));
        chk("cmd_code", cmd, CMD_RD);
      end
      ret_addr.push_back(addr);
      ret_due.push_back(cyc + $urandom_range(lat_max, lat_min));
      n_cmd++;
    end
    hold_prev = cmd_en && !cmd_ready;
    hold_addr = addr;

    rd_data_valid = 1'b0;
    if (ret_addr.size() > 0 && ret_due[0] <= cyc) begin
      ra = ret_addr.pop_front();
      void'(ret_due.pop_front());
      rd_data_valid = 1'b1;
      rd_data = data_of(ra);
    end

    if (mhold_prev) begin
      chk("m_hold_valid", m_valid, 1'b1);
      chk("m_hold_data", m_data, mhold_dat);
      chk("m_hold_last", m_last, mhold_last);
    end
    m_ready = ($urandom_range(99) < p_m);
    if (m_valid && m_ready) begin
      if (frame_active) begin
        chk("beat_data", m_data, data_of(exp_addr(f_bank, n_pop)));
        chk("beat_last", m_last, (n_pop == f_total - 1));
        if (n_pop == f_total - 1) last_pop_prev = 1;
      end
      n_pop++;
    end
    mhold_prev = m_valid && !m_ready;
    mhold_dat  = m_data;
    mhold_last = m_last;
  endtask

  task automatic start_frame(input logic [2:0] b, input logic [13:0] re, input logic [9:0] ce);
    f_bank = b;
    f_total = int'(re) * 128 + int'(ce[9:3]) + 1;
    n_cmd = 0;
    n_pop = 0;
    frame_active = 1;
    bank_sel = b;
    row_end = re;
    col_end = ce;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  // run to completion; optionally poke start and drop calibration mid-frame
  task automatic finish_frame(input logic exp_err, input int budget, input bit poke);
    int k;
    k = 0;
    while (1) begin
      step();
      if (poke && k == 5) begin
        start = 1'b1;
        bank_sel = ~f_bank;
        row_end = 14'd5;
        init_calib_complete = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (last_pop_prev) break;
      k++;
      if (k > budget) begin
        chk("frame_timeout", n_pop, f_total);
        break;
      end
    end
    init_calib_complete = 1'b1;
    step();
    chk("busy_after_done", busy, 1'b0);
    chk("cmd_count", n_cmd, f_total);
    chk("beat_count", n_pop, f_total);
    chk("err_state", err, exp_err);
    frame_active = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cmd_en"}, cmd_en, 1'b0);
    chk({tag, "_cmd"}, cmd, 3'd0);
    chk({tag, "_addr"}, addr, 27'd0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_m_data"}, m_data, 128'd0);
  endtask

  initial begin
    int k;
    init_calib_complete = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    chk("reset_err", err, 1'b0);
    chk("burst_number", app_burst_number, 6'd0);
    rst_n = 1'b1;
    step();

    // single beat, fixed latency 10
    p_cmd = 100; p_m = 100; lat_min = 10; lat_max = 10;
    start_frame(3'd2, 14'd0, 10'd0);
    finish_frame(1'b0, 200, 0);

    // row wrap: 130 beats
    p_m = 70; lat_min = 1; lat_max = 6;
    start_frame(3'd1, 14'd1, 10'd8);
    finish_frame(1'b0, 2000, 0);

    // backpressure: 100-beat frame with stream stalled
    p_cmd = 100; p_m = 0; lat_min = 2; lat_max = 5;
    start_frame(3'd3, 14'd0, 10'd792);
    repeat (40) step();
    chk("bp_cmds", n_cmd, DEPTH);
    chk("bp_cmd_en", cmd_en, 1'b0);
    p_m = 100;
    step();
    p_m = 0;
    repeat (20) step();
    chk("bp_one_more", n_cmd, DEPTH + 1);
    chk("bp_cmd_en2", cmd_en, 1'b0);
    p_m = 100;
    finish_frame(1'b0, 2000, 0);

    // start without calibration is ignored
    init_calib_complete = 1'b0;
    bank_sel = 3'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("nocal_busy", busy, 1'b0);
    chk("nocal_cmds", ret_addr.size(), 0);
    init_calib_complete = 1'b1;

    // random command stalls and latencies; first frame also gets a start while busy
    for (int f = 0; f < 4; f++) begin
      p_cmd = 50; p_m = 60; lat_min = 1; lat_max = 12;
      start_frame(3'($urandom_range(7)), 14'($urandom_range(2)), 10'($urandom_range(1023)));
      finish_frame(1'b0, 6000, f == 0);
    end

    // reset with three reads outstanding; their late returns must set err
    p_cmd = 100; p_m = 100; lat_min = 40; lat_max = 40;
    start_frame(3'd5, 14'd0, 10'd152);
    k = 0;
    while (n_cmd < 3 && k < 50) begin
      step();
      k++;
    end
    p_cmd = 0;
    step();
    chk("outstanding_at_reset", ret_addr.size(), 3);
    rst_n = 1'b0;
    hold_prev = 0;
    mhold_prev = 0;
    frame_active = 0;
    step();
    check_reset_outputs("midrst");
    chk("midrst_err", err, 1'b0);
    rst_n = 1'b1;
    k = 0;
    while (ret_addr.size() > 0 && k < 100) begin
      step();
      k++;
    end
    chk("returns_drained", ret_addr.size(), 0);
    step();
    chk("late_err", err, 1'b1);
    chk("late_m_valid", m_valid, 1'b0);
    chk("late_cmd_en", cmd_en, 1'b0);

    // full frame after the error, err stays sticky
    p_cmd = 60; p_m = 80; lat_min = 1; lat_max = 8;
    start_frame(3'd6, 14'd1, 10'd40);
    finish_frame(1'b1, 3000, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_frame_reader.md
Name: ddr3_frame_reader

Overview:
- Read-side client of the DDR3MI user interface, running on the DDR controller's half-memory clock (`clk_out` of the IP).
- Given a JPEG buffer slot (DDR bank) and its end row/column, it issues single-burst read commands from row 0, column 0 up to and including the end address.
- Returned 128-bit beats are buffered in an internal FIFO and presented as a valid/ready stream to the UDP packetiser.
- It is the reader counterpart to the frame-writing path that fills the banks.

Parameters:
- FIFO_DEPTH, 16, read-data FIFO depth in 128-bit beats; power of two, ≥4.
- DATA_W, 128, app data width.
- CMD_RD, 3'b001, DDR3MI read command encoding.

Ports:
- clk  input  1  DDR3MI user clock (half memory clock)
- rst_n  input  1  asynchronous active-low reset
- init_calib_complete  input  1  DDR calibration done
- start  input  1  one-cycle request to read a frame
- bank_sel  input  3  buffer slot (DDR bank) to read
- row_end  input  14  last row of the frame, inclusive
- col_end  input  10  last column of the frame, inclusive; bits [2:0] ignored
- busy  output  1  frame read in progress
- done  output  1  one-cycle pulse when the last beat is accepted downstream
- err  output  1  sticky; rd_data_valid arrived with no read outstanding
- cmd_ready  input  1  controller accepts a command
- cmd  output  3  command code
- cmd_en  output  1  command valid
- addr  output  27  {bank[2:0], row[13:0], col[9:0]}
- app_burst_number  output  6  constant 0 (one burst per command)
- rd_data  input  128  read data
- rd_data_valid  input  1  read data beat valid
- rd_data_end  input  1  end of burst; unused, since each burst is one beat
- m_data  output  128  stream data
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready
- m_last  output  1  final beat of the frame

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; outstanding counter 0; err 0.
- Data unit: one command is one BL8 read, which returns exactly one 128-bit beat. Column step is 8.
- Beat count: total = row_end*128 + col_end[9:3] + 1 (22-bit arithmetic). Maximum is 2^21.
- Start capture: start is accepted only in IDLE with init_calib_complete=1. It latches bank_sel, row_end and col_end[9:3], clears the row/col/issued/delivered counters, and moves to ISSUE. Start in any other condition is ignored; busy stays unchanged.
- busy: 1 in ISSUE and DRAIN.
- ISSUE state: cmd_en=1, cmd=CMD_RD, addr={bank,row,col} whenever credit is available, otherwise cmd_en=0.
  - Credit: outstanding + fifo_count < FIFO_DEPTH.
  - Handshake: cmd_en & cmd_ready. On a handshake, outstanding increments and col += 8. When col wraps from 1016 to 0, row increments.
  - addr and cmd are stable while cmd_en=1 and cmd_ready=0.
  - Leaving ISSUE: the handshake for the last address (row==row_end, col==col_end) moves to DRAIN, with cmd_en=0 on the next cycle.
- Read return: rd_data_valid with outstanding>0 writes rd_data into the FIFO and decrements outstanding. Credit guarantees the FIFO never overflows.
  - Handshake and return in the same cycle: outstanding is unchanged.
  - rd_data_valid with outstanding==0: data is dropped and err is set until reset.
- Stream output: m_valid = FIFO not empty, m_data = FIFO head. A beat pops on m_valid & m_ready.
  - m_last=1 when the head beat is number total-1 of the frame (delivered counter).
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
- DRAIN state: exits when the last beat pops. Next cycle: done=1 for one cycle, busy=0, state IDLE.
- First beat latency: FIFO write at the rd_data_valid edge, m_valid the following cycle. First-word fall-through, no extra register.
- FIFO: simultaneous push and pop in the same cycle are both honoured, and fifo_count is unchanged.
- Calibration loss: init_calib_complete dropping mid-frame has no effect; the frame completes.
- Reset mid-operation: asynchronous return to reset values. Beats returned after reset while outstanding==0 set err; the bench expects this.

Test Plan:
- Single beat: bank_sel=2, row_end=0, col_end=0, cmd_ready=1, read latency 10 → one command with addr=27'h2000000; one beat with m_last=1; done one cycle after the pop; busy low after that.
- Row wrap: bank_sel=1, row_end=1, col_end=8 → 130 commands; addresses col 0..1016 step 8 on row 0, then row 1 col 0 and col 8; m_last only on beat 129.
- Backpressure: FIFO_DEPTH=8, m_ready=0, 100-beat frame → exactly 8 handshakes, then cmd_en=0. Setting m_ready=1 for one cycle re-enables exactly one more command.
- Command stall: cmd_ready toggled randomly → addr and cmd held while not accepted; no address skipped or duplicated; data order matches a memory model.
- Start ignored: start with init_calib_complete=0, and start while busy → no commands issued; no change to the latched frame.
- Error/reset: rst_n asserted with 3 reads outstanding, then the model returns 3 beats → err=1; m_valid=0; cmd_en=0. A subsequent start reads a full frame correctly.
